complex_invert_apply: RTL and testbench

COMPLEX_INVERT_APPLY -- requirements
Module: complex_invert_apply

---
 rtl/complex_invert_apply.sv | 125 ++++++++++++
 tb/tb_complex_invert_apply.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_invert_apply.sv
// Applies a per-packet complex coefficient (Q1.15 sc16) to a sample stream: y = x*h, 3-stage pipeline.
// Define COMPLEX_INVERT_APPLY_SAT_EN to clip results to int16; otherwise results wrap to 16 bits.
module complex_invert_apply #(
  parameter int SCALE_SHIFT = 15
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [31:0] c_tdata,
  input  logic        c_tlast,
  input  logic        c_tvalid,
  output logic        c_tready,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sc16_t;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam int STAGES = 2;
  localparam logic signed [33:0] RND = 34'sd1 <<< (SCALE_SHIFT - 1);

  state_t             state, state_nxt;
  logic               ce, accept;
  logic [STAGES:0]    vld_pipe, last_pipe;
  sc16_t              coef, x_s0, h_s0;
  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [33:0] sum_re, sum_im, rnd_re, rnd_im;
  logic [15:0]        y_re, y_im;
  logic               unused_bits;

  assign ce          = ~vld_pipe[STAGES] | o_tready;
  assign accept      = i_tvalid & i_tready;
  assign o_tvalid    = vld_pipe[STAGES];
  assign o_tlast     = last_pipe[STAGES];
  assign unused_bits = ^{c_tlast, rnd_re[33:16], rnd_im[33:16]};

  // FSM: state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= LOAD;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (c_tvalid)          state_nxt = RUN;
      RUN:  if (accept && i_tlast) state_nxt = LOAD;
      default:                     state_nxt = LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    c_tready = 1'b0;
    i_tready = 1'b0;
    case (state)
      LOAD:    c_tready = 1'b1;
      RUN:     i_tready = ce;
      default: c_tready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                coef <= '0;
    else if (c_tvalid && c_tready) coef <= c_tdata;
  end

  // The coefficient travels with each sample so a reload cannot corrupt beats still in flight.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      x_s0      <= '0;
      h_s0      <= '0;
      p_rr      <= '0;
      p_ii      <= '0;
      p_ri      <= '0;
      p_ir      <= '0;
      o_tdata   <= '0;
    end else if (ce) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
      last_pipe <= {last_pipe[STAGES-1:0], accept & i_tlast};
      if (accept) begin
        x_s0 <= i_tdata;
        h_s0 <= coef;
      end
      p_rr    <= 32'(x_s0.re) * 32'(h_s0.re);
      p_ii    <= 32'(x_s0.im) * 32'(h_s0.im);
      p_ri    <= 32'(x_s0.re) * 32'(h_s0.im);
      p_ir    <= 32'(x_s0.im) * 32'(h_s0.re);
      o_tdata <= {y_re, y_im};
    end
  end

  // Sum, round half-up, scale, reduce to 16 bits.
  always_comb begin
    sum_re = 34'(p_rr) - 34'(p_ii);
    sum_im = 34'(p_ri) + 34'(p_ir);
    rnd_re = (sum_re + RND) >>> SCALE_SHIFT;
    rnd_im = (sum_im + RND) >>> SCALE_SHIFT;
`ifdef COMPLEX_INVERT_APPLY_SAT_EN
    if      (rnd_re > 34'sd32767)  y_re = 16'h7FFF;
    else if (rnd_re < -34'sd32768) y_re = 16'h8000;
    else                           y_re = rnd_re[15:0];
    if      (rnd_im > 34'sd32767)  y_im = 16'h7FFF;
    else if (rnd_im < -34'sd32768) y_im = 16'h8000;
    else                           y_im = rnd_im[15:0];
`else
    y_re = rnd_re[15:0];
    y_im = rnd_im[15:0];
`endif
  end

endmodule

// File: tb/tb_complex_invert_apply.sv
// Directed table vectors plus hand-written packet, reset and random-backpressure sequences.
module tb_complex_invert_apply;
  logic        clk = 1'b0, aresetn = 1'b0;
  logic [31:0] c_tdata = '0, i_tdata = '0, o_tdata;
  logic        c_tlast = 1'b0, c_tvalid = 1'b0, c_tready;
  logic        i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
  logic        o_tlast, o_tvalid, o_tready = 1'b1;

  always #5 clk = ~clk;

  complex_invert_apply #(.SCALE_SHIFT(15)) dut (
    .clk(clk), .aresetn(aresetn),
    .c_tdata(c_tdata), .c_tlast(c_tlast), .c_tvalid(c_tvalid), .c_tready(c_tready),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  typedef struct { logic [31:0] d; logic l; int cyc; } beat_t;
  typedef struct { logic [31:0] d; logic l; } exp_t;
  typedef struct { string name; logic [31:0] h; logic [31:0] x; logic [31:0] y; } vec_t;

  beat_t got_q[$];
  exp_t  exp_q[$];
  int    acc_q[$];
  int    cyc = 0;
  int    n_cmp = 0, n_bad = 0;
  logic  rnd_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [15:0] red(input longint v);
`ifdef COMPLEX_INVERT_APPLY_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] h, input logic [31:0] x);
    longint hr = longint'($signed(h[31:16]));
    longint hi = longint'($signed(h[15:0]));
    longint xr = longint'($signed(x[31:16]));
    longint xi = longint'($signed(x[15:0]));
    longint yr = (xr * hr - xi * hi + 16384) >>> 15;
    longint yi = (xr * hi + xi * hr + 16384) >>> 15;
    return {red(yr), red(yi)};
  endfunction

  // All drivers run aligned to posedge+2; o_tready changes at posedge+1.
  task automatic load_coef(input logic [31:0] h);
    int n = 0;
    c_tdata  = h;
    c_tvalid = 1'b1;
    while (!c_tready && n < 50) begin @(posedge clk); #2; n++; end
    if (!c_tready) fail_now("coef_handshake");
    @(posedge clk); #2;
    c_tvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] x, input logic last);
    int n = 0;
    i_tdata  = x;
    i_tlast  = last;
    i_tvalid = 1'b1;
    while (!i_tready && n < 200) begin @(posedge clk); #2; n++; end
    if (!i_tready) fail_now("sample_handshake");
    acc_q.push_back(cyc);
    @(posedge clk); #2;
  endtask

  task automatic idle_i();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic wait_out(output beat_t b);
    int n = 0;
    while (got_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    if (got_q.size() == 0) begin
      fail_now("output_wait");
      b = '{32'hDEADBEEF, 1'b0, 0};
    end else b = got_q.pop_front();
    @(posedge clk); #2;
  endtask

  vec_t  tbl[7];
  beat_t b0, b1;

  initial begin
    tbl[0] = '{"unity",      32'h7FFF_0000, 32'h03E8_F830, 32'h03E8_F830};
    tbl[1] = '{"half_j",     32'h0000_4000, 32'h07D0_03E8, 32'hFE0C_03E8};
`ifdef COMPLEX_INVERT_APPLY_SAT_EN
    tbl[2] = '{"neg1_sq",    32'h8000_0000, 32'h8000_0000, 32'h7FFF_0000};
    tbl[6] = '{"cplx_ovf",   32'h8000_8000, 32'h7FFF_7FFF, 32'h0000_8000};
`else
    tbl[2] = '{"neg1_sq",    32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    tbl[6] = '{"cplx_ovf",   32'h8000_8000, 32'h7FFF_7FFF, 32'h0000_0002};
`endif
    tbl[3] = '{"half",       32'h4000_0000, 32'h1F40_0000, 32'h0FA0_0000};
    tbl[4] = '{"quarter",    32'h2000_0000, 32'h1F40_0000, 32'h07D0_0000};
    tbl[5] = '{"round_half", 32'h4000_4000, 32'h0064_00C8, 32'hFFCE_0096};

    // Output monitor with stall-stability check, and the o_tready driver.
    fork
      begin
        logic        prev_stall = 1'b0, prev_l = 1'b0;
        logic [31:0] prev_d = '0;
        forever begin
          @(negedge clk);
          if (aresetn) begin
            if (prev_stall) begin
              check("stall_valid", 32'(o_tvalid), 32'd1);
              check("stall_data", o_tdata, prev_d);
              check("stall_last", 32'(o_tlast), 32'(prev_l));
            end
            if (o_tvalid && o_tready) got_q.push_back('{o_tdata, o_tlast, cyc});
            prev_stall = o_tvalid & ~o_tready;
            prev_d     = o_tdata;
            prev_l     = o_tlast;
          end else prev_stall = 1'b0;
        end
      end
      forever begin
        @(posedge clk); #1;
        o_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_o_tlast", 32'(o_tlast), 32'd0);
    check("rst_o_tdata", o_tdata, 32'd0);
    check("rst_i_tready", 32'(i_tready), 32'd0);
    aresetn = 1'b1;
    @(posedge clk); #2;
    check("rel_c_tready", 32'(c_tready), 32'd1);
    check("rel_i_tready", 32'(i_tready), 32'd0);

    // Two-beat packet through unity coefficient, latency and tlast
    got_q.delete();
    acc_q.delete();
    load_coef(32'h7FFF_0000);
    send_beat(32'h03E8_F830, 1'b0);
    send_beat(32'h0003_0004, 1'b1);
    idle_i();
    wait_out(b0);
    wait_out(b1);
    check("pkt_beat0", b0.d, 32'h03E8_F830);
    check("pkt_last0", 32'(b0.l), 32'd0);
    check("pkt_beat1", b1.d, 32'h0003_0004);
    check("pkt_last1", 32'(b1.l), 32'd1);
    check("pkt_lat0", 32'(b0.cyc - acc_q[0]), 32'd3);
    check("pkt_lat1", 32'(b1.cyc - acc_q[1]), 32'd3);

    // Table vectors, one single-beat packet each
    for (int i = 0; i < 7; i++) begin
      got_q.delete();
      load_coef(tbl[i].h);
      send_beat(tbl[i].x, 1'b1);
      idle_i();
      wait_out(b0);
      check(tbl[i].name, b0.d, tbl[i].y);
      check({tbl[i].name, "_last"}, 32'(b0.l), 32'd1);
    end

    // Back-to-back packets: sample held off until the new coefficient lands
    got_q.delete();
    load_coef(32'h4000_0000);
    send_beat(32'h1F40_0000, 1'b1);
    i_tdata = 32'h1F40_0000;
    i_tlast = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("gap_i_tready", 32'(i_tready), 32'd0);
      @(posedge clk); #2;
    end
    load_coef(32'h2000_0000);
    send_beat(32'h1F40_0000, 1'b1);
    idle_i();
    wait_out(b0);
    wait_out(b1);
    check("two_pkt_first", b0.d, 32'h0FA0_0000);
    check("two_pkt_second", b1.d, 32'h07D0_0000);
    repeat (5) @(posedge clk);
    #2;
    check("two_pkt_no_extra", 32'(got_q.size()), 32'd0);

    // Reset mid-packet
    got_q.delete();
    load_coef(32'h7FFF_0000);
    send_beat(32'h0000_000A, 1'b0);
    send_beat(32'h0000_0014, 1'b0);
    send_beat(32'h0000_001E, 1'b0);
    check("pre_rst_o_tvalid", 32'(o_tvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_o_tvalid", 32'(o_tvalid), 32'd0);
    check("mid_rst_c_tready", 32'(c_tready), 32'd1);
    check("mid_rst_i_tready", 32'(i_tready), 32'd0);
    check("mid_rst_o_tdata", o_tdata, 32'd0);
    @(posedge clk); #2;
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      check("post_rst_c_tready", 32'(c_tready), 32'd1);
      check("post_rst_i_tready", 32'(i_tready), 32'd0);
      check("post_rst_o_tvalid", 32'(o_tvalid), 32'd0);
    end
    check("post_rst_no_out", 32'(got_q.size()), 32'd0);
    idle_i();
    load_coef(32'h4000_0000);
    send_beat(32'h1F40_0000, 1'b1);
    idle_i();
    wait_out(b0);
    check("post_rst_beat", b0.d, 32'h0FA0_0000);

    // Random data, random backpressure, 10 packets of 100 beats
    got_q.delete();
    exp_q.delete();
    rnd_en = 1'b1;
    for (int p = 0; p < 10; p++) begin
      logic [31:0] h;
      h = $urandom;
      load_coef(h);
      for (int k = 0; k < 100; k++) begin
        logic [31:0] x;
        x = $urandom;
        exp_q.push_back('{model(h, x), k == 99});
        send_beat(x, k == 99);
      end
      idle_i();
    end
    begin
      int n = 0;
      while (got_q.size() < 1000 && n < 20000) begin @(negedge clk); n++; end
    end
    rnd_en = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("rand_count", 32'(got_q.size()), 32'd1000);
    for (int i = 0; i < 1000; i++) begin
      exp_t e;
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      b0 = got_q.pop_front();
      e  = exp_q.pop_front();
      check("rand_data", b0.d, e.d);
      check("rand_last", 32'(b0.l), 32'(e.l));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
